vga_frame_receiver: RTL

VGA_FRAME_RECEIVER -- requirements
Module: vga_frame_receiver

---
 rtl/vga_frame_receiver.sv | 169 ++++++++++++++++
 1 files changed

// File: rtl/vga_frame_receiver.sv
// VGA timing receiver: measures line and frame length from the sync inputs,
// locks when they match the expected totals, and samples one active pixel per frame.
module vga_frame_receiver #(
  parameter int H_TOTAL = 800,
  parameter int V_TOTAL = 525,
  parameter int PROBE_X = 320,
  parameter int PROBE_Y = 240
) (
  input  logic        CLOCK_50,
  input  logic        reset,
  input  logic        iVGA_CLK,
  input  logic        iHS,
  input  logic        iVS,
  input  logic        iBLANK_n,
  input  logic [7:0]  iR,
  input  logic [7:0]  iG,
  input  logic [7:0]  iB,
  output logic [10:0] line_len,
  output logic [10:0] frame_lines,
  output logic        locked,
  output logic        frame_done,
  output logic [23:0] probe_rgb,
  output logic        probe_valid,
  output logic        err
);

  localparam logic [10:0] CNT_MAX = 11'h7FF;
  localparam logic [10:0] H_EXP   = 11'(H_TOTAL);
  localparam logic [10:0] V_EXP   = 11'(V_TOTAL);
  localparam logic [10:0] PX      = 11'(PROBE_X);
  localparam logic [10:0] PY      = 11'(PROBE_Y);

  typedef enum logic [1:0] {SEARCH, MEASURE, CHECK, LOCK} state_t;
  state_t state_reg, state_next;

  logic        vga_clk_reg, hs_reg, vs_reg;
  logic [10:0] x_reg, y_reg, col_reg, row_reg;
  logic        line_active_reg, bad_line_reg;
  logic [10:0] line_len_reg, frame_lines_reg;
  logic [23:0] probe_rgb_reg;
  logic        probe_hit_reg, probe_valid_reg;
  logic        locked_reg, locked_next;
  logic        err_reg, err_next;
  logic        frame_done_reg, frame_done_next;

  logic        tick, hs_fall, vs_fall, capture;
  logic        line_ok, frame_ok, frame_clean;
  logic [10:0] x_inc, y_inc, y_line;

  assign tick    = iVGA_CLK & ~vga_clk_reg;
  assign hs_fall = tick & hs_reg & ~iHS;
  assign vs_fall = tick & vs_reg & ~iVS;
  assign x_inc   = (x_reg == CNT_MAX) ? CNT_MAX : x_reg + 11'd1;
  assign y_inc   = (y_reg == CNT_MAX) ? CNT_MAX : y_reg + 11'd1;
  // A line ending on the same tick as the frame still counts towards that frame.
  assign y_line      = hs_fall ? y_inc : y_reg;
  assign line_ok     = (x_inc == H_EXP);
  assign frame_ok    = (y_line == V_EXP);
  assign frame_clean = ~bad_line_reg & ~(hs_fall & ~line_ok);
  assign capture     = tick & iBLANK_n & (col_reg == PX) & (row_reg == PY);

  always_ff @(posedge CLOCK_50 or posedge reset) begin
    if (reset) begin
      // Sync history starts low so only a fresh high-to-low transition counts.
      vga_clk_reg     <= 1'b1;
      hs_reg          <= 1'b0;
      vs_reg          <= 1'b0;
      x_reg           <= '0;
      y_reg           <= '0;
      col_reg         <= '0;
      row_reg         <= '0;
      line_active_reg <= 1'b0;
      bad_line_reg    <= 1'b0;
      line_len_reg    <= '0;
      frame_lines_reg <= '0;
      probe_rgb_reg   <= '0;
      probe_hit_reg   <= 1'b0;
      probe_valid_reg <= 1'b0;
    end else begin
      vga_clk_reg     <= iVGA_CLK;
      probe_hit_reg   <= capture;
      probe_valid_reg <= probe_hit_reg;
      if (tick) begin
        hs_reg <= iHS;
        vs_reg <= iVS;
        x_reg  <= hs_fall ? 11'd0 : x_inc;
        if (hs_fall) line_len_reg <= x_inc;
        if (vs_fall) begin
          frame_lines_reg <= y_line;
          y_reg           <= '0;
        end else begin
          y_reg <= y_line;
        end
        if (hs_fall) begin
          col_reg         <= '0;
          line_active_reg <= 1'b0;
        end else if (iBLANK_n) begin
          col_reg         <= col_reg + 11'd1;
          line_active_reg <= 1'b1;
        end
        if (vs_fall) row_reg <= '0;
        else if (hs_fall && line_active_reg) row_reg <= row_reg + 11'd1;
        if (vs_fall) bad_line_reg <= 1'b0;
        else if (hs_fall && !line_ok) bad_line_reg <= 1'b1;
        if (capture) probe_rgb_reg <= {iR, iG, iB};
      end
    end
  end

  always_ff @(posedge CLOCK_50 or posedge reset) begin
    if (reset) begin
      state_reg      <= SEARCH;
      locked_reg     <= 1'b0;
      err_reg        <= 1'b0;
      frame_done_reg <= 1'b0;
    end else begin
      state_reg      <= state_next;
      locked_reg     <= locked_next;
      err_reg        <= err_next;
      frame_done_reg <= frame_done_next;
    end
  end

  always_comb begin
    state_next      = state_reg;
    locked_next     = locked_reg;
    err_next        = err_reg;
    frame_done_next = 1'b0;
    case (state_reg)
      SEARCH: if (vs_fall) state_next = MEASURE;
      MEASURE: begin
        if (vs_fall) begin
          state_next      = CHECK;
          frame_done_next = 1'b1;
        end
      end
      CHECK: begin
        if (vs_fall) begin
          frame_done_next = 1'b1;
          if (frame_clean && frame_ok) begin
            state_next  = LOCK;
            locked_next = 1'b1;
          end else begin
            state_next = MEASURE;
            err_next   = 1'b1;
          end
        end
      end
      LOCK: begin
        frame_done_next = vs_fall;
        if ((hs_fall && !line_ok) || (vs_fall && !frame_ok)) begin
          state_next  = MEASURE;
          locked_next = 1'b0;
          err_next    = 1'b1;
        end
      end
      default: state_next = SEARCH;
    endcase
  end

  assign line_len    = line_len_reg;
  assign frame_lines = frame_lines_reg;
  assign locked      = locked_reg;
  assign frame_done  = frame_done_reg;
  assign probe_rgb   = probe_rgb_reg;
  assign probe_valid = probe_valid_reg;
  assign err         = err_reg;

endmodule
